fir_result_fifo: RTL



---
 rtl/fir_pkg.sv | 8 +
 rtl/fir_result_fifo.sv | 73 +++++++
 2 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: constants shared across the FIR accelerator and its result FIFO
package fir_pkg;
   localparam int DATA_WIDTH  = 16;
   localparam int NUM_REGS    = 8;
   localparam int FIFO_DEPTH  = 8;
   localparam int FIFO_THRESH = 4;
   localparam int DROP_CNT_W  = 8;
endpackage

// File: rtl/fir_result_fifo.sv
// fir_result_fifo: first-word-fall-through result buffer with level, threshold and drop accounting
module fir_result_fifo #(
   parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
   parameter int DEPTH      = fir_pkg::FIFO_DEPTH,
   parameter int THRESH     = fir_pkg::FIFO_THRESH
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         clr,
   input  logic [DATA_WIDTH-1:0]        inData,
   input  logic                         inValid,
   output logic [DATA_WIDTH-1:0]        outData,
   output logic                         outValid,
   input  logic                         outReady,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         thresholdIrq,
   output logic                         overflow,
   input  logic                         overflowClr,
   output logic [fir_pkg::DROP_CNT_W-1:0] dropCount
);
   import fir_pkg::*;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic full, empty, pop, push, drop;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;
   assign pop   = !empty && outReady;
   assign push  = inValid && (!full || pop);
   assign drop  = inValid && full && !pop;
   assign outValid     = !empty;
   assign outData      = empty ? '0 : mem[rd_ptr];
   assign level        = count;
   assign thresholdIrq = count >= CW'(THRESH);
   // storage write; flush discards the incoming result
   always_ff @(posedge clk) begin
      if (push && !clr) mem[wr_ptr] <= inData;
   end
   // pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end
   // sticky overflow and saturating drop counter; a drop beats a same-cycle clear
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         overflow  <= 1'b0;
         dropCount <= '0;
      end else if (clr) begin
         overflow  <= 1'b0;
         dropCount <= '0;
      end else if (drop) begin
         overflow  <= 1'b1;
         dropCount <= overflowClr ? DROP_CNT_W'(1) : (&dropCount ? dropCount : dropCount + 1'b1);
      end else if (overflowClr) begin
         overflow  <= 1'b0;
         dropCount <= '0;
      end
   end
endmodule
